// File: rtl/csr_unit.sv
// csr_unit: Zicsr register file (tohost, scratch bank, cycle/instret counters)
// with a single-cycle registered read-modify-write path back to writeback.
module csr_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_WIDTH   = 64,
  parameter int NUM_SCRATCH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_src_zero,
  input  logic            retire,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            illegal,
  output logic [XLEN-1:0] tohost,
  output logic            tohost_wr
);

  logic [XLEN-1:0]        tohost_r;
  logic [XLEN-1:0]        scratch_r [NUM_SCRATCH];
  logic [CNT_WIDTH-1:0]   cycle_r;
  logic [CNT_WIDTH-1:0]   instret_r;
  logic [XLEN-1:0]        rdata_r;
  logic                   rdata_valid_r;
  logic                   illegal_r;
  logic                   tohost_wr_r;

  logic [XLEN-1:0]        old_s;
  logic [XLEN-1:0]        new_s;
  logic [XLEN-1:0]        cyc_hi_s;
  logic [XLEN-1:0]        ins_hi_s;
  logic [11:0]            scr_off_s;
  logic [NUM_SCRATCH-1:0] sel_scr_s;
  logic                   sel_tohost_s;
  logic                   mapped_s;
  logic                   ro_s;
  logic                   op_ok_s;
  logic                   wr_s;
  logic                   illegal_s;
  logic                   accept_s;
  logic                   wen_s;

  // Upper counter halves are zero-extended to XLEN
  assign cyc_hi_s  = XLEN'(cycle_r >> XLEN);
  assign ins_hi_s  = XLEN'(instret_r >> XLEN);
  assign scr_off_s = req_addr - 12'h340;
  assign accept_s  = req_valid & ~stall;

  // Address decode: pick the target CSR and fetch its pre-write value
  always_comb begin
    old_s        = '0;
    mapped_s     = 1'b0;
    ro_s         = 1'b0;
    sel_tohost_s = 1'b0;
    sel_scr_s    = '0;
    case (req_addr)
      12'h51E: begin
        old_s        = tohost_r;
        mapped_s     = 1'b1;
        sel_tohost_s = 1'b1;
      end
      12'hC00: begin
        old_s    = cycle_r[XLEN-1:0];
        mapped_s = 1'b1;
        ro_s     = 1'b1;
      end
      12'hC80: begin
        old_s    = cyc_hi_s;
        mapped_s = 1'b1;
        ro_s     = 1'b1;
      end
      12'hC02: begin
        old_s    = instret_r[XLEN-1:0];
        mapped_s = 1'b1;
        ro_s     = 1'b1;
      end
      12'hC82: begin
        old_s    = ins_hi_s;
        mapped_s = 1'b1;
        ro_s     = 1'b1;
      end
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (scr_off_s == 12'(i)) begin
            old_s        = scratch_r[i];
            mapped_s     = 1'b1;
            sel_scr_s[i] = 1'b1;
          end else begin
            sel_scr_s[i] = 1'b0;
          end
        end
      end
    endcase
  end

  // Operation decode: new value and whether this op actually writes
  always_comb begin
    new_s   = old_s;
    wr_s    = 1'b0;
    op_ok_s = 1'b1;
    case (req_op)
      3'b001, 3'b101: begin
        new_s = req_wdata;
        wr_s  = 1'b1;
      end
      3'b010, 3'b110: begin
        new_s = old_s | req_wdata;
        wr_s  = ~req_src_zero;
      end
      3'b011, 3'b111: begin
        new_s = old_s & ~req_wdata;
        wr_s  = ~req_src_zero;
      end
      default: begin
        new_s   = old_s;
        wr_s    = 1'b0;
        op_ok_s = 1'b0;
      end
    endcase
  end

  // A read-only CSR is only illegal when the op would really write it
  assign illegal_s = ~op_ok_s | ~mapped_s | (ro_s & wr_s);
  assign wen_s     = accept_s & wr_s & ~illegal_s;

  // State update: counters, CSR writes and the registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost_r      <= '0;
      cycle_r       <= '0;
      instret_r     <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
      tohost_wr_r   <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_r[i] <= '0;
      end
    end else begin
      cycle_r     <= cycle_r + CNT_WIDTH'(1);
      tohost_wr_r <= wen_s & sel_tohost_s;
      if (!stall) begin
        if (retire) begin
          instret_r <= instret_r + CNT_WIDTH'(1);
        end
        rdata_valid_r <= req_valid;
        illegal_r     <= req_valid & illegal_s;
        rdata_r       <= (req_valid && !illegal_s) ? old_s : '0;
      end
      if (wen_s && sel_tohost_s) begin
        tohost_r <= new_s;
      end
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wen_s && sel_scr_s[i]) begin
          scratch_r[i] <= new_s;
        end
      end
    end
  end

  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign illegal     = illegal_r;
  assign tohost      = tohost_r;
  assign tohost_wr   = tohost_wr_r;

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit: default instance plus a narrow
// XLEN=8 / CNT_WIDTH=12 instance used to exercise counter carry and wrap.
module tb_csr_unit;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_BAD = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_src_zero;
  logic        retire;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        illegal;
  logic [31:0] tohost;
  logic        tohost_wr;

  logic        s2_stall;
  logic        s2_valid;
  logic [2:0]  s2_op;
  logic [11:0] s2_addr;
  logic [7:0]  s2_wdata;
  logic        s2_src_zero;
  logic        s2_retire;
  logic [7:0]  s2_rdata;
  logic        s2_rdata_valid;
  logic        s2_illegal;
  logic [7:0]  s2_tohost;
  logic        s2_tohost_wr;

  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] exp_c;
  int          wait_n;
  int          checks;
  int          errors;

  csr_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_src_zero(req_src_zero), .retire(retire), .rdata(rdata),
    .rdata_valid(rdata_valid), .illegal(illegal), .tohost(tohost),
    .tohost_wr(tohost_wr)
  );

  csr_unit #(.XLEN(8), .CNT_WIDTH(12), .NUM_SCRATCH(1)) dut_small (
    .clk(clk), .reset(reset), .stall(s2_stall), .req_valid(s2_valid),
    .req_op(s2_op), .req_addr(s2_addr), .req_wdata(s2_wdata),
    .req_src_zero(s2_src_zero), .retire(s2_retire), .rdata(s2_rdata),
    .rdata_valid(s2_rdata_valid), .illegal(s2_illegal), .tohost(s2_tohost),
    .tohost_wr(s2_tohost_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference counters derived from the bench's own reset/stall/retire drive
  always @(posedge clk) begin
    if (!reset) begin
      m_cycle   <= 64'd0;
      m_instret <= 64'd0;
    end else begin
      m_cycle <= m_cycle + 64'd1;
      if (retire && !stall) m_instret <= m_instret + 64'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, input logic sz);
    req_valid    = 1'b1;
    req_op       = op;
    req_addr     = addr;
    req_wdata    = wd;
    req_src_zero = sz;
    step();
    req_valid    = 1'b0;
  endtask

  task automatic req2(input logic [11:0] addr);
    s2_valid    = 1'b1;
    s2_op       = OP_RS;
    s2_addr     = addr;
    s2_wdata    = 8'h00;
    s2_src_zero = 1'b1;
    step();
    s2_valid    = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; stall = 1'b0; retire = 1'b0;
    req_valid = 1'b0; req_op = OP_NOP; req_addr = 12'h000; req_wdata = 32'h0; req_src_zero = 1'b0;
    s2_stall = 1'b0; s2_retire = 1'b0; s2_valid = 1'b0; s2_op = OP_NOP;
    s2_addr = 12'h000; s2_wdata = 8'h00; s2_src_zero = 1'b0;
    step(); step();
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_valid", 64'(rdata_valid), 64'h0);
    check("rst_illegal", 64'(illegal), 64'h0);
    check("rst_tohost", 64'(tohost), 64'h0);
    check("rst_tohost_wr", 64'(tohost_wr), 64'h0);
    reset = 1'b1;

    // Ten cycles out of reset, then read cycle without writing
    repeat (10) step();
    req(OP_RS, 12'hC00, 32'h0, 1'b1);
    check("cyc10_rdata", 64'(rdata), 64'd10);
    check("cyc10_illegal", 64'(illegal), 64'h0);
    check("cyc10_valid", 64'(rdata_valid), 64'h1);
    req(OP_RS, 12'hC00, 32'h5, 1'b0);
    check("cyc_ro_wr_illegal", 64'(illegal), 64'h1);
    exp_c = m_cycle[31:0];
    req(OP_RS, 12'hC00, 32'h0, 1'b1);
    check("cyc_unaffected", 64'(rdata), 64'(exp_c));
    req(OP_RS, 12'hC80, 32'h0, 1'b1);
    check("cyc_hi_zero", 64'(rdata), 64'h0);

    // tohost write pulse, including a rewrite of the same value
    req(OP_RW, 12'h51E, 32'h1, 1'b0);
    check("th_rdata", 64'(rdata), 64'h0);
    check("th_valid", 64'(rdata_valid), 64'h1);
    check("th_value", 64'(tohost), 64'h1);
    check("th_wr", 64'(tohost_wr), 64'h1);
    step();
    check("th_wr_drop", 64'(tohost_wr), 64'h0);
    check("idle_valid", 64'(rdata_valid), 64'h0);
    req(OP_RWI, 12'h51E, 32'h1, 1'b0);
    check("th_same_rdata", 64'(rdata), 64'h1);
    check("th_same_wr", 64'(tohost_wr), 64'h1);

    // Scratch read-modify-write, back to back
    req(OP_RW, 12'h342, 32'hF0F0F0F0, 1'b0);
    check("scr_first", 64'(rdata), 64'h0);
    req(OP_RC, 12'h342, 32'h000000FF, 1'b0);
    check("scr_rc_old", 64'(rdata), 64'hF0F0F0F0);
    req(OP_RS, 12'h342, 32'h00000001, 1'b0);
    check("scr_rs_old", 64'(rdata), 64'hF0F0F000);
    req(OP_RC, 12'h342, 32'hFFFFFFFF, 1'b1);
    check("scr_final", 64'(rdata), 64'hF0F0F001);
    req(OP_RS, 12'h342, 32'h0, 1'b1);
    check("scr_rc_suppressed", 64'(rdata), 64'hF0F0F001);
    req(OP_RWI, 12'h343, 32'h1F, 1'b0);
    check("scr3_first", 64'(rdata), 64'h0);
    req(OP_RS, 12'h343, 32'h0, 1'b1);
    check("scr3_val", 64'(rdata), 64'h1F);
    req(OP_RS, 12'h340, 32'h0, 1'b1);
    check("scr0_untouched", 64'(rdata), 64'h0);
    req(OP_RW, 12'h344, 32'h12, 1'b0);
    check("scr_above_illegal", 64'(illegal), 64'h1);
    check("scr_above_rdata", 64'(rdata), 64'h0);
    req(OP_RW, 12'h33F, 32'h12, 1'b0);
    check("scr_below_illegal", 64'(illegal), 64'h1);

    // Unmapped address and illegal funct3
    req(OP_RW, 12'h7FF, 32'hABCD, 1'b0);
    check("unmapped_illegal", 64'(illegal), 64'h1);
    check("unmapped_rdata", 64'(rdata), 64'h0);
    req(OP_BAD, 12'h51E, 32'h7, 1'b0);
    check("f3_100_illegal", 64'(illegal), 64'h1);
    check("f3_100_rdata", 64'(rdata), 64'h0);
    check("f3_100_tohost", 64'(tohost), 64'h1);
    check("f3_100_tohost_wr", 64'(tohost_wr), 64'h0);
    req(OP_NOP, 12'h342, 32'hFFFFFFFF, 1'b0);
    check("f3_000_illegal", 64'(illegal), 64'h1);

    // instret counts only unstalled retires
    retire = 1'b1;
    repeat (3) step();
    retire = 1'b0;
    req(OP_RS, 12'hC02, 32'h0, 1'b1);
    check("instret3", 64'(rdata), 64'd3);
    req(OP_RS, 12'hC82, 32'h0, 1'b1);
    check("instret_hi", 64'(rdata), 64'h0);

    // Stall holds response and blocks both request and retire
    req(OP_RS, 12'h342, 32'h0, 1'b1);
    stall = 1'b1; retire = 1'b1;
    req_valid = 1'b1; req_op = OP_RW; req_addr = 12'h51E; req_wdata = 32'hDEAD; req_src_zero = 1'b0;
    repeat (5) step();
    check("stall_rdata", 64'(rdata), 64'hF0F0F001);
    check("stall_valid", 64'(rdata_valid), 64'h1);
    check("stall_tohost", 64'(tohost), 64'h1);
    check("stall_tohost_wr", 64'(tohost_wr), 64'h0);
    stall = 1'b0; retire = 1'b0; req_valid = 1'b0;
    exp_c = m_cycle[31:0];
    req(OP_RS, 12'hC00, 32'h0, 1'b1);
    check("stall_cycle", 64'(rdata), 64'(exp_c));
    req(OP_RS, 12'hC02, 32'h0, 1'b1);
    check("stall_instret", 64'(rdata), 64'd3);

    // Reset during stall with a pending request
    req(OP_RS, 12'h51E, 32'h0, 1'b1);
    stall = 1'b1; reset = 1'b0;
    req_valid = 1'b1; req_op = OP_RW; req_addr = 12'h51E; req_wdata = 32'h5; req_src_zero = 1'b0;
    step();
    check("mrst_rdata", 64'(rdata), 64'h0);
    check("mrst_valid", 64'(rdata_valid), 64'h0);
    check("mrst_illegal", 64'(illegal), 64'h0);
    check("mrst_tohost", 64'(tohost), 64'h0);
    check("mrst_tohost_wr", 64'(tohost_wr), 64'h0);
    reset = 1'b1; stall = 1'b0; req_valid = 1'b0;
    step();
    check("mrst_dropped", 64'(tohost), 64'h0);
    req(OP_RS, 12'h342, 32'h0, 1'b1);
    check("mrst_scratch", 64'(rdata), 64'h0);
    exp_c = m_cycle[31:0];
    req(OP_RS, 12'hC00, 32'h0, 1'b1);
    check("mrst_cycle", 64'(rdata), 64'(exp_c));

    // Narrow instance: carry from low to high word, then full wrap
    wait_n = 255 - int'(m_cycle[31:0]);
    repeat (wait_n) step();
    req2(12'hC80);
    check("w_hi_ff", 64'(s2_rdata), 64'h00);
    check("w_hi_ff_ill", 64'(s2_illegal), 64'h0);
    req2(12'hC00);
    check("w_lo_100", 64'(s2_rdata), 64'h00);
    req2(12'hC80);
    check("w_hi_101", 64'(s2_rdata), 64'h01);
    wait_n = 4095 - int'(m_cycle[31:0]);
    repeat (wait_n) step();
    req2(12'hC80);
    check("w_hi_fff", 64'(s2_rdata), 64'h0F);
    req2(12'hC00);
    check("w_lo_wrap", 64'(s2_rdata), 64'h00);
    req2(12'hC80);
    check("w_hi_wrap", 64'(s2_rdata), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
